// File: rtl/sum_nine_pkg.sv
// Shared types and constants for the divide-by-nine datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sum_nine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIVISOR = 9;
  localparam int REM_W   = 4;

  // Number of restoring-division iterations for a WIDTH-bit addend sum.
  function automatic int iter_count(input int width);
    return width + 4;
  endfunction

endpackage

// File: rtl/sum_nine_divider_div9_step.sv
// One restoring-division step by the constant nine (combinational).
// Latency: 0 cycles.
// Backpressure: none; pure function of its inputs.
module div9_step
  import sum_nine_pkg::*;
(
  input  logic [REM_W-1:0] rem_in,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem_out,
  output logic             q_bit
);

  logic [REM_W:0] partial;

  // Shift in the next dividend bit and subtract nine when it fits.
  always_comb begin
    partial = {rem_in, bit_in};
    q_bit   = (partial >= (REM_W+1)'(DIVISOR));
    rem_out = q_bit ? REM_W'(partial - (REM_W+1)'(DIVISOR)) : partial[REM_W-1:0];
  end

endmodule

// File: rtl/sum_nine_divider.sv
// Divides a nine-operand sum by nine; optional rounding via SUM_NINE_DIV_ROUND_EN.
// Latency: out_valid rises WIDTH+5 edges after the accepting edge.
// Backpressure: one job at a time; result held stable until out_ready.
module sum_nine_divider
  import sum_nine_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+3:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_quot,
  output logic [REM_W-1:0] out_rem
);

  localparam int DW    = WIDTH + 4;
  localparam int CNT_W = $clog2(DW + 1);

  state_t           state;
  logic [DW-1:0]    dividend;
  logic [DW-1:0]    quot;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_nxt;
  logic             q_bit;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   quot_fin;

  div9_step u_step (
    .rem_in  (rem),
    .bit_in  (dividend[DW-1]),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

`ifdef SUM_NINE_DIV_ROUND_EN
  // Round half up on the final remainder; cannot overflow the WIDTH+1 result.
  assign quot_fin = quot[WIDTH:0] + (WIDTH+1)'(rem >= REM_W'(5));
`else
  assign quot_fin = quot[WIDTH:0];
`endif

  // Control FSM, iteration counter and MSB-first shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dividend  <= '0;
      quot      <= '0;
      rem       <= '0;
      cnt       <= '0;
      out_quot  <= '0;
      out_rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= DIV;
            in_ready <= 1'b0;
            dividend <= in_sum;
            quot     <= '0;
            rem      <= '0;
            cnt      <= CNT_W'(iter_count(WIDTH));
          end
        end
        DIV: begin
          if (cnt != '0) begin
            dividend <= {dividend[DW-2:0], 1'b0};
            quot     <= {quot[DW-2:0], q_bit};
            rem      <= rem_nxt;
            cnt      <= cnt - CNT_W'(1);
          end else begin
            // All bits consumed: register the result and present it.
            state     <= DONE;
            out_valid <= 1'b1;
            out_quot  <= quot_fin;
            out_rem   <= rem;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The top three quotient bits can never be set: (2^(WIDTH+4)-1)/9 < 2^(WIDTH+1).
  assert property (@(posedge clk) disable iff (!rst_n) quot[DW-1:WIDTH+1] == '0);

endmodule

// File: tb/tb_sum_nine_divider.sv
// Scoreboard bench for sum_nine_divider at WIDTH=32 and WIDTH=4.
// Latency: checks the WIDTH+5 edge result latency on a directed case.
// Backpressure: randomised out_ready; results popped only on handshake.
module tb_sum_nine_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v32, r32, ov32, o32;
  logic [35:0] s32;
  logic [32:0] q32;
  logic [3:0]  m32;
  logic        v4, r4, ov4, o4;
  logic [7:0]  s4;
  logic [4:0]  q4;
  logic [3:0]  m4;

  sum_nine_divider #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_sum(s32),
    .out_valid(ov32), .out_ready(o32), .out_quot(q32), .out_rem(m32)
  );

  sum_nine_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_sum(s4),
    .out_valid(ov4), .out_ready(o4), .out_quot(q4), .out_rem(m4)
  );

  typedef struct { logic [32:0] q; logic [3:0] r; } e32_t;
  typedef struct { logic [4:0]  q; logic [3:0] r; } e4_t;

  e32_t eq32[$];
  e4_t  eq4[$];
  e32_t cur32;
  e4_t  cur4;
  int   total = 0;
  int   bad = 0;
  int   sent32 = 0, got32 = 0, sent4 = 0, got4 = 0;
  bit   stop = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic e32_t mk32(input logic [32:0] q, input logic [3:0] r);
    e32_t e;
    e.q = q;
    e.r = r;
    return e;
  endfunction

  // Reference: plain integer division, optionally rounded half up.
  function automatic e32_t model32(input logic [35:0] s);
    longint unsigned v, q, r;
    v = 64'(s);
    q = v / 9;
    r = v % 9;
`ifdef SUM_NINE_DIV_ROUND_EN
    if (r >= 5) q = q + 1;
`endif
    return mk32(33'(q), 4'(r));
  endfunction

  function automatic e4_t model4(input logic [7:0] s);
    int v, q, r;
    e4_t e;
    v = int'(s);
    q = v / 9;
    r = v % 9;
`ifdef SUM_NINE_DIV_ROUND_EN
    if (r >= 5) q = q + 1;
`endif
    e.q = 5'(q);
    e.r = 4'(r);
    return e;
  endfunction

  // Monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (rst_n && ov32 && o32) begin
      if (eq32.size() == 0) begin
        total++; bad++;
        $display("FAIL dut32 unexpected result: got q=%0h r=%0d want none", q32, m32);
      end else begin
        cur32 = eq32.pop_front();
        chk("dut32 quot", 64'(q32), 64'(cur32.q));
        chk("dut32 rem", 64'(m32), 64'(cur32.r));
      end
      got32++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov4 && o4) begin
      if (eq4.size() == 0) begin
        total++; bad++;
        $display("FAIL dut4 unexpected result: got q=%0h r=%0d want none", q4, m4);
      end else begin
        cur4 = eq4.pop_front();
        chk("dut4 quot", 64'(q4), 64'(cur4.q));
        chk("dut4 rem", 64'(m4), 64'(cur4.r));
      end
      got4++;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send32(input logic [35:0] val, input e32_t exp);
    int n = 0;
    v32 = 1'b1;
    s32 = val;
    @(negedge clk);
    while (!r32 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!r32) begin
      total++; bad++;
      $display("FAIL dut32 accept timeout: got in_ready=0 want 1");
    end else begin
      eq32.push_back(exp);
      sent32++;
    end
    @(posedge clk); #1;
    v32 = 1'b0;
    s32 = 'x;
  endtask

  task automatic send4(input logic [7:0] val);
    int n = 0;
    v4 = 1'b1;
    s4 = val;
    @(negedge clk);
    while (!r4 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!r4) begin
      total++; bad++;
      $display("FAIL dut4 accept timeout: got in_ready=0 want 1");
    end else begin
      eq4.push_back(model4(val));
      sent4++;
    end
    @(posedge clk); #1;
    v4 = 1'b0;
    s4 = 'x;
  endtask

  task automatic wait_valid32(output int n);
    n = 0;
    while (!ov32 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_idle32();
    int n = 0;
    while (!r32 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("dut32 returns idle", 64'(r32), 64'd1);
  endtask

  initial begin
    int lat;
    logic [35:0] rv;
    v32 = 1'b0; s32 = 'x; o32 = 1'b1;
    v4  = 1'b0; s4  = 'x; o4  = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst in_ready32", 64'(r32), 64'd1);
    chk("rst out_valid32", 64'(ov32), 64'd0);
    chk("rst quot32", 64'(q32), 64'd0);
    chk("rst rem32", 64'(m32), 64'd0);
    chk("rst in_ready4", 64'(r4), 64'd1);
    chk("rst out_valid4", 64'(ov4), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 100 -> 11 r1, with latency
    send32(36'd100, mk32(33'd11, 4'd1));
    wait_valid32(lat);
    chk("latency 100", 64'(lat), 64'd37);
    wait_idle32();

`ifdef SUM_NINE_DIV_ROUND_EN
    send32(36'd104, mk32(33'd12, 4'd5));
`else
    send32(36'd104, mk32(33'd11, 4'd5));
`endif
    wait_idle32();
    send32(36'h8_FFFF_FFF7, mk32(33'h0_FFFF_FFFF, 4'd0));
    wait_idle32();
    send32(36'hF_FFFF_FFFF, mk32(33'h1_C71C_71C7, 4'd0));
    wait_idle32();

    // Hold result under backpressure; in_valid pulses must be ignored
    o32 = 1'b0;
    send32(36'd0, mk32(33'd0, 4'd0));
    wait_valid32(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      v32 = (i % 2) == 0;
      s32 = {4'($urandom_range(0, 15)), 32'($urandom)};
      @(negedge clk);
      chk("hold out_valid", 64'(ov32), 64'd1);
      chk("hold in_ready", 64'(r32), 64'd0);
      chk("hold quot", 64'(q32), 64'd0);
      chk("hold rem", 64'(m32), 64'd0);
    end
    @(posedge clk); #1;
    v32 = 1'b0; s32 = 'x; o32 = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 64'(ov32), 64'd0);
    chk("release in_ready", 64'(r32), 64'd1);

    // Abort mid-division with reset
    send32(36'd1000, model32(36'd1000));
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    eq32.delete();
    @(negedge clk);
    chk("abort out_valid", 64'(ov32), 64'd0);
    chk("abort in_ready", 64'(r32), 64'd1);
    chk("abort quot", 64'(q32), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post-abort out_valid", 64'(ov32), 64'd0);
    chk("post-abort in_ready", 64'(r32), 64'd1);
    @(posedge clk); #1;
    send32(36'd18, mk32(33'd2, 4'd0));
    wait_idle32();

    // Random back-to-back traffic on both widths with random out_ready
    sent32 = 0; got32 = 0; sent4 = 0; got4 = 0;
    fork
      begin
        while (!stop) begin
          @(posedge clk); #1;
          if (!stop) begin
            o32 = ($urandom_range(0, 3) != 0);
            o4  = ($urandom_range(0, 3) != 0);
          end
        end
      end
    join_none
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          case ($urandom_range(0, 7))
            0: rv = 36'hF_FFFF_FFFF;
            1: rv = 36'($urandom_range(0, 40));
            default: rv = {4'($urandom_range(0, 15)), 32'($urandom)};
          endcase
          send32(rv, model32(rv));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          send4(8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
      end
    join

    begin
      int n = 0;
      while ((eq32.size() != 0 || eq4.size() != 0) && n < 2000) begin
        @(posedge clk);
        n++;
      end
    end
    stop = 1'b1;
    @(posedge clk); #1;
    o32 = 1'b1; o4 = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("dut32 pending results", 64'(eq32.size()), 64'd0);
    chk("dut4 pending results", 64'(eq4.size()), 64'd0);
    chk("dut32 accepted", 64'(sent32), 64'd1000);
    chk("dut4 accepted", 64'(sent4), 64'd1000);
    chk("dut32 delivered", 64'(got32), 64'(sent32));
    chk("dut4 delivered", 64'(got4), 64'(sent4));
    chk("dut32 quiet", 64'(ov32), 64'd0);
    chk("dut4 quiet", 64'(ov4), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
